// File: rtl/branch_predict_resolve_if.sv
// Bundle of fetch-side prediction, execute-side resolve and statistics
// signals for the branch unit.  The comparator flag bit positions come from
// the shared parameter header when it is present; the fallbacks below give a
// two-bit {GT, EQ} flag bus.
`ifndef BC_FLAG_COUNT
`define BC_FLAG_COUNT 2
`endif
`ifndef BC_FLAG_GT
`define BC_FLAG_GT 1
`endif
`ifndef BC_FLAG_EQ
`define BC_FLAG_EQ 0
`endif

// Handshake: there is no backpressure.  res_valid qualifies exactly one
// resolve beat in the cycle it is high and there is no ready signal; the unit
// always accepts.  pc_sel/flush are one-cycle pulses in the cycle after the
// accepted beat.  Fetch prediction is a pure combinational lookup.
interface branch_predict_resolve_if #(
    parameter int PC_W          = 8,
    parameter int BC_FLAG_COUNT = `BC_FLAG_COUNT,
    parameter int CNT_W         = 16
);
    logic [PC_W-1:0]          pred_pc;
    logic [4:0]               pred_opcode;
    logic                     pred_taken;
    logic                     res_valid;
    logic [PC_W-1:0]          res_pc;
    logic [4:0]               res_opcode;
    logic [BC_FLAG_COUNT-1:0] res_bc_flags;
    logic                     res_pred_taken;
    logic                     stat_clr;
    logic                     pc_sel;
    logic                     flush;
    logic [CNT_W-1:0]         stat_branches;
    logic [CNT_W-1:0]         stat_mispred;

    // Pipeline side: drives fetch/resolve requests, consumes results.
    modport master (
        output pred_pc, pred_opcode, res_valid, res_pc, res_opcode,
               res_bc_flags, res_pred_taken, stat_clr,
        input  pred_taken, pc_sel, flush, stat_branches, stat_mispred
    );

    // Branch unit side.
    modport slave (
        input  pred_pc, pred_opcode, res_valid, res_pc, res_opcode,
               res_bc_flags, res_pred_taken, stat_clr,
        output pred_taken, pc_sel, flush, stat_branches, stat_mispred
    );
endinterface

// File: rtl/branch_predict_resolve.sv
// Branch unit: bimodal 2-bit counter prediction at fetch, resolution and
// table training at execute, registered pc_sel/flush pulses and saturating
// statistics counters.
`ifndef BC_FLAG_COUNT
`define BC_FLAG_COUNT 2
`endif
`ifndef BC_FLAG_GT
`define BC_FLAG_GT 1
`endif
`ifndef BC_FLAG_EQ
`define BC_FLAG_EQ 0
`endif

module branch_predict_resolve #(
    parameter int PC_W          = 8,
    parameter int BHT_DEPTH     = 16,
    parameter int BC_FLAG_COUNT = `BC_FLAG_COUNT,
    parameter int CNT_W         = 16
) (
    input logic                      clk,
    input logic                      rst_n,
    branch_predict_resolve_if.slave  bus
);
    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        BK_NONE,
        BK_JUMP,
        BK_BLT,
        BK_BGE,
        BK_BEQ,
        BK_BNEQ
    } br_kind_t;

    function automatic br_kind_t decode(input logic [4:0] op);
        br_kind_t k;
        case (op[4:1])
            4'b1011, 4'b1100: k = BK_JUMP;
            4'b1101:          k = BK_BLT;
            4'b1110:          k = BK_BGE;
            4'b1111:          k = op[0] ? BK_BNEQ : BK_BEQ;
            default:          k = BK_NONE;
        endcase
        return k;
    endfunction

    logic [1:0]       bht [BHT_DEPTH];
    br_kind_t         pred_kind;
    br_kind_t         res_kind;
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] res_idx;
    logic             res_gt;
    logic             res_eq;
    logic             actual_taken;
    logic             res_is_cond;
    logic             res_is_br;
    logic             mispred;
    logic             pc_sel_q;
    logic             flush_q;
    logic [CNT_W-1:0] stat_branches_q;
    logic [CNT_W-1:0] stat_mispred_q;
    logic             unused_bits;

    // Upper PC bits only matter to the pipeline, not to table indexing.
    assign unused_bits = ^{bus.pred_pc, bus.res_pc, bus.res_bc_flags};

    // Fetch-side prediction: reads the table as it stands before any
    // same-cycle training write (no bypass on index collision).
    always_comb begin
        pred_kind      = decode(bus.pred_opcode);
        pred_idx       = bus.pred_pc[IDX_W-1:0];
        bus.pred_taken = 1'b0;
        case (pred_kind)
            BK_JUMP:                    bus.pred_taken = 1'b1;
            BK_BLT, BK_BGE,
            BK_BEQ, BK_BNEQ:            bus.pred_taken = bht[pred_idx][1];
            default:                    bus.pred_taken = 1'b0;
        endcase
    end

    // Execute-side resolution of the actual outcome from opcode and flags.
    always_comb begin
        res_kind     = decode(bus.res_opcode);
        res_idx      = bus.res_pc[IDX_W-1:0];
        res_gt       = bus.res_bc_flags[`BC_FLAG_GT];
        res_eq       = bus.res_bc_flags[`BC_FLAG_EQ];
        actual_taken = 1'b0;
        case (res_kind)
            BK_JUMP: actual_taken = 1'b1;
            BK_BLT:  actual_taken = ~res_gt & ~res_eq;
            BK_BGE:  actual_taken = res_gt | res_eq;
            BK_BEQ:  actual_taken = res_eq;
            BK_BNEQ: actual_taken = ~res_eq;
            default: actual_taken = 1'b0;
        endcase
        res_is_br   = (res_kind != BK_NONE);
        res_is_cond = res_is_br && (res_kind != BK_JUMP);
        // A non-branch predicted taken is also a mispredict: fetch went the
        // wrong way and must return to fall-through.
        mispred     = bus.res_valid && (actual_taken != bus.res_pred_taken);
    end

    // Train the counter of a resolved conditional branch, saturating both ways.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (bus.res_valid && res_is_cond) begin
            if (actual_taken && (bht[res_idx] != 2'b11)) begin
                bht[res_idx] <= bht[res_idx] + 2'b01;
            end else if (!actual_taken && (bht[res_idx] != 2'b00)) begin
                bht[res_idx] <= bht[res_idx] - 2'b01;
            end
        end
    end

    // One-cycle redirect and kill pulses for the PC mux and pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_sel_q <= 1'b0;
            flush_q  <= 1'b0;
        end else begin
            pc_sel_q <= bus.res_valid & actual_taken;
            flush_q  <= mispred;
        end
    end

    // Saturating statistics; a clear wins over an event in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else if (bus.stat_clr) begin
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            if (bus.res_valid && res_is_br && (stat_branches_q != CNT_MAX)) begin
                stat_branches_q <= stat_branches_q + CNT_W'(1);
            end
            if (mispred && (stat_mispred_q != CNT_MAX)) begin
                stat_mispred_q <= stat_mispred_q + CNT_W'(1);
            end
        end
    end

    assign bus.pc_sel        = pc_sel_q;
    assign bus.flush         = flush_q;
    assign bus.stat_branches = stat_branches_q;
    assign bus.stat_mispred  = stat_mispred_q;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Bench for branch_predict_resolve: directed vector table, hand-written
// collision / saturation / reset sequences, then random stimulus against a
// behavioural model of the branch rules.
`ifndef BC_FLAG_COUNT
`define BC_FLAG_COUNT 2
`endif
`ifndef BC_FLAG_GT
`define BC_FLAG_GT 1
`endif
`ifndef BC_FLAG_EQ
`define BC_FLAG_EQ 0
`endif

module tb_branch_predict_resolve;
    localparam int PC_W      = 8;
    localparam int BHT_DEPTH = 16;
    localparam int FLAG_N    = `BC_FLAG_COUNT;
    localparam int CNT_W     = 8;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    localparam logic [4:0] OP_JMPADR = 5'h16;
    localparam logic [4:0] OP_JMPI   = 5'h18;
    localparam logic [4:0] OP_BLT    = 5'h1A;
    localparam logic [4:0] OP_BGE    = 5'h1C;
    localparam logic [4:0] OP_BEQ    = 5'h1E;
    localparam logic [4:0] OP_BNEQ   = 5'h1F;
    localparam logic [4:0] OP_NOP    = 5'h00;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    branch_predict_resolve_if #(.PC_W(PC_W), .BC_FLAG_COUNT(FLAG_N), .CNT_W(CNT_W)) bus ();

    branch_predict_resolve #(
        .PC_W(PC_W), .BHT_DEPTH(BHT_DEPTH), .BC_FLAG_COUNT(FLAG_N), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- reference model ----------------
    int n_vec;
    int n_miss;
    int bht_m [BHT_DEPTH];
    int m_branches;
    int m_mispred;
    int m_pc_sel;
    int m_flush;

    function automatic int grp_of(input logic [4:0] op);
        return int'(op) / 2;
    endfunction

    function automatic int model_actual(input logic [4:0] op, input logic gt, input logic eq);
        int g;
        g = grp_of(op);
        if (g == 11 || g == 12) return 1;
        if (g == 13) return (!gt && !eq) ? 1 : 0;
        if (g == 14) return (gt || eq) ? 1 : 0;
        if (g == 15) return (int'(op) % 2 == 0) ? int'(eq) : int'(!eq);
        return 0;
    endfunction

    function automatic int model_pred(input logic [7:0] pc, input logic [4:0] op);
        int g;
        g = grp_of(op);
        if (g == 11 || g == 12) return 1;
        if (g >= 13) return (bht_m[int'(pc) % BHT_DEPTH] >= 2) ? 1 : 0;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < BHT_DEPTH; i++) bht_m[i] = 1;
        m_branches = 0;
        m_mispred  = 0;
        m_pc_sel   = 0;
        m_flush    = 0;
    endtask

    // Called just after each rising edge with the inputs that edge sampled.
    task automatic model_step();
        int g;
        int act;
        int rv;
        int miss;
        int idx;
        if (!rst_n) return;
        g    = grp_of(bus.res_opcode);
        act  = model_actual(bus.res_opcode, bus.res_bc_flags[`BC_FLAG_GT],
                            bus.res_bc_flags[`BC_FLAG_EQ]);
        rv   = int'(bus.res_valid);
        miss = (rv == 1 && act != int'(bus.res_pred_taken)) ? 1 : 0;
        idx  = int'(bus.res_pc) % BHT_DEPTH;
        if (rv == 1 && g >= 13) begin
            if (act == 1) bht_m[idx] = (bht_m[idx] < 3) ? bht_m[idx] + 1 : 3;
            else          bht_m[idx] = (bht_m[idx] > 0) ? bht_m[idx] - 1 : 0;
        end
        if (bus.stat_clr) begin
            m_branches = 0;
            m_mispred  = 0;
        end else begin
            if (rv == 1 && g >= 11 && m_branches < CNT_MAX) m_branches++;
            if (miss == 1 && m_mispred < CNT_MAX) m_mispred++;
        end
        m_pc_sel = rv & act;
        m_flush  = miss;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".pc_sel"}, int'(bus.pc_sel), m_pc_sel);
        check({tag, ".flush"}, int'(bus.flush), m_flush);
        check({tag, ".stat_branches"}, int'(bus.stat_branches), m_branches);
        check({tag, ".stat_mispred"}, int'(bus.stat_mispred), m_mispred);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [7:0] ppc, input logic [4:0] pop, input logic rv,
                         input logic [7:0] rpc, input logic [4:0] rop, input logic gt,
                         input logic eq, input logic rpt, input logic clr);
        logic [FLAG_N-1:0] f;
        f = '0;
        f[`BC_FLAG_GT] = gt;
        f[`BC_FLAG_EQ] = eq;
        bus.pred_pc        = ppc;
        bus.pred_opcode    = pop;
        bus.res_valid      = rv;
        bus.res_pc         = rpc;
        bus.res_opcode     = rop;
        bus.res_bc_flags   = f;
        bus.res_pred_taken = rpt;
        bus.stat_clr       = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        drive(8'h00, OP_NOP, 1'b0, 8'h00, OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [7:0] pred_pc;
        logic [4:0] pred_op;
        logic       rv;
        logic [7:0] res_pc;
        logic [4:0] res_op;
        logic       gt;
        logic       eq;
        logic       rpt;
        logic       exp_pc_sel;
        logic       exp_flush;
        logic       exp_pred_post;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] ppc, input logic [4:0] pop, input logic rv,
                                input logic [7:0] rpc, input logic [4:0] rop, input logic gt,
                                input logic eq, input logic rpt, input logic ps,
                                input logic fl, input logic pp);
        vec_t v;
        v.pred_pc = ppc; v.pred_op = pop; v.rv = rv; v.res_pc = rpc; v.res_op = rop;
        v.gt = gt; v.eq = eq; v.rpt = rpt;
        v.exp_pc_sel = ps; v.exp_flush = fl; v.exp_pred_post = pp;
        return v;
    endfunction

    vec_t vecs [20];

    initial begin
        logic [4:0] op_pick [6];
        logic [4:0] rop;
        logic [4:0] pop;
        n_vec  = 0;
        n_miss = 0;
        rst_n  = 1'b0;
        model_reset();
        drive(8'h00, OP_NOP, 1'b0, 8'h00, OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0);

        // table: pred pc/op, res valid/pc/op, gt, eq, pred carried, -> pc_sel, flush, pred after edge
        vecs[0]  = mk(8'h05, OP_BEQ,    1, 8'h05, OP_BEQ,    0, 1, 0, 1, 1, 1);
        vecs[1]  = mk(8'h03, OP_BLT,    1, 8'h03, OP_BLT,    0, 0, 0, 1, 1, 1);
        vecs[2]  = mk(8'h03, OP_BLT,    1, 8'h03, OP_BLT,    0, 0, 1, 1, 0, 1);
        vecs[3]  = mk(8'h03, OP_BLT,    1, 8'h03, OP_BLT,    0, 0, 1, 1, 0, 1);
        vecs[4]  = mk(8'h03, OP_BLT,    1, 8'h03, OP_BLT,    0, 0, 1, 1, 0, 1);
        vecs[5]  = mk(8'h03, OP_BLT,    1, 8'h03, OP_BLT,    1, 0, 1, 0, 1, 1);
        vecs[6]  = mk(8'h03, OP_BLT,    1, 8'h03, OP_BLT,    1, 0, 1, 0, 1, 0);
        vecs[7]  = mk(8'h03, OP_BLT,    1, 8'h03, OP_BLT,    1, 0, 1, 0, 1, 0);
        vecs[8]  = mk(8'h03, OP_BLT,    1, 8'h03, OP_BLT,    1, 0, 1, 0, 1, 0);
        vecs[9]  = mk(8'h07, OP_BGE,    1, 8'h07, OP_BGE,    0, 1, 0, 1, 1, 1);
        vecs[10] = mk(8'h07, OP_BGE,    1, 8'h07, OP_BGE,    1, 0, 1, 1, 0, 1);
        vecs[11] = mk(8'h08, OP_BGE,    1, 8'h08, OP_BGE,    0, 0, 0, 0, 0, 0);
        vecs[12] = mk(8'h09, OP_BLT,    1, 8'h09, OP_BLT,    0, 1, 0, 0, 0, 0);
        vecs[13] = mk(8'h0A, OP_BLT,    1, 8'h0A, OP_JMPI,   0, 0, 1, 1, 0, 0);
        vecs[14] = mk(8'h0B, OP_BLT,    1, 8'h0B, OP_NOP,    0, 0, 1, 0, 1, 0);
        vecs[15] = mk(8'h05, OP_BEQ,    0, 8'h05, OP_BEQ,    0, 1, 0, 0, 0, 1);
        vecs[16] = mk(8'h06, OP_BNEQ,   1, 8'h06, OP_BNEQ,   0, 0, 0, 1, 1, 1);
        vecs[17] = mk(8'h06, OP_BNEQ,   1, 8'h06, OP_BNEQ,   0, 1, 1, 0, 1, 0);
        vecs[18] = mk(8'h04, OP_JMPADR, 1, 8'h04, OP_JMPADR, 0, 0, 0, 1, 1, 1);
        vecs[19] = mk(8'h05, OP_NOP,    1, 8'h05, OP_NOP,    1, 1, 0, 0, 0, 0);

        // reset state
        repeat (2) @(negedge clk);
        check("reset.pc_sel", int'(bus.pc_sel), 0);
        check("reset.flush", int'(bus.flush), 0);
        check("reset.stats", int'(bus.stat_branches) + int'(bus.stat_mispred), 0);
        rst_n = 1'b1;

        // directed table
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].pred_pc, vecs[i].pred_op, vecs[i].rv, vecs[i].res_pc,
                  vecs[i].res_op, vecs[i].gt, vecs[i].eq, vecs[i].rpt, 1'b0);
            tick();
            check($sformatf("vec%0d.pc_sel", i), int'(bus.pc_sel), int'(vecs[i].exp_pc_sel));
            check($sformatf("vec%0d.flush", i), int'(bus.flush), int'(vecs[i].exp_flush));
            check($sformatf("vec%0d.pred_taken", i), int'(bus.pred_taken),
                  int'(vecs[i].exp_pred_post));
            check($sformatf("vec%0d.stat_branches", i), int'(bus.stat_branches), m_branches);
        end
        check("table.stat_branches", int'(bus.stat_branches), 17);
        check("table.stat_mispred", int'(bus.stat_mispred), 11);

        // aliasing pcs 0x12/0x02 with same-cycle update and predict
        apply_reset();
        drive(8'h12, OP_BEQ, 1'b1, 8'h02, OP_BEQ, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 check("alias.pre0", int'(bus.pred_taken), 0);
        tick();
        check("alias.post0", int'(bus.pred_taken), 1);
        #1 check("alias.pre1", int'(bus.pred_taken), 1);
        tick();
        check("alias.post1", int'(bus.pred_taken), 1);
        drive(8'h02, OP_BEQ, 1'b1, 8'h12, OP_BEQ, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check("alias.post2", int'(bus.pred_taken), 1);
        #1 check("alias.pre3", int'(bus.pred_taken), 1);
        tick();
        check("alias.post3", int'(bus.pred_taken), 0);
        check_outputs("alias");

        // stat saturation, clear priority, mid-pulse reset
        apply_reset();
        drive(8'h00, OP_NOP, 1'b1, 8'h00, OP_JMPI, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (CNT_MAX + 5) tick();
        check("sat.stat_branches", int'(bus.stat_branches), CNT_MAX);
        check("sat.stat_mispred", int'(bus.stat_mispred), CNT_MAX);
        tick();
        check("sat.hold", int'(bus.stat_mispred), CNT_MAX);
        drive(8'h00, OP_NOP, 1'b1, 8'h00, OP_JMPI, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check("clr.stat_branches", int'(bus.stat_branches), 0);
        check("clr.stat_mispred", int'(bus.stat_mispred), 0);
        check("clr.flush", int'(bus.flush), 1);
        drive(8'h00, OP_NOP, 1'b1, 8'h00, OP_JMPI, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("midrst.flush_before", int'(bus.flush), 1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst.flush", int'(bus.flush), 0);
        check("midrst.pc_sel", int'(bus.pc_sel), 0);
        check("midrst.stat_mispred", int'(bus.stat_mispred), 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(8'h05, OP_BEQ, 1'b0, 8'h00, OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 check("midrst.bht_weak_nt", int'(bus.pred_taken), 0);

        // random stimulus against the model
        op_pick[0] = OP_JMPADR; op_pick[1] = OP_JMPI; op_pick[2] = OP_BLT;
        op_pick[3] = OP_BGE;    op_pick[4] = OP_BEQ;  op_pick[5] = OP_BNEQ;
        @(negedge clk);
        for (int n = 0; n < 1500; n++) begin
            logic [7:0] ppc;
            logic [7:0] rpc;
            ppc = 8'($urandom_range(0, 255));
            rpc = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255)) : ppc;
            pop = ($urandom_range(0, 7) < 6) ? op_pick[$urandom_range(0, 5)]
                                             : 5'($urandom_range(0, 31));
            rop = ($urandom_range(0, 7) < 6) ? op_pick[$urandom_range(0, 5)]
                                             : 5'($urandom_range(0, 31));
            drive(ppc, pop, 1'($urandom_range(0, 3) != 0), rpc, rop,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
            #1 check("rand.pred_taken", int'(bus.pred_taken), model_pred(ppc, pop));
            tick();
            check_outputs("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
